// File: rtl/adc_scan_sequencer.sv
// Serial front-end controller for an 8-channel 12-bit SAR ADC (LTC2308-style).
// Scans channels round-robin; each result is strobed with the channel whose config produced it.
module adc_scan_sequencer #(
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned CFG_BITS    = 6,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CONV_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 adc_sdo,
    output logic                 adc_convst,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    output logic                 sample_valid,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [2:0]           sample_ch,
    output logic                 busy
);

    localparam int unsigned CNT_MAX = (CONV_CYCLES > DATA_BITS) ? CONV_CYCLES : DATA_BITS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 phase_q;
    logic [2:0]           ch_q;
    logic [2:0]           prev_ch_q;
    logic                 first_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [CFG_BITS-1:0]  cfg_sr_q;
    logic [CFG_BITS-1:0]  cfg_d;
    logic [2:0]           ch_next_d;

    // Config word: single-ended, odd/sign, select1, select0, unipolar, no sleep.
    always_comb begin
        cfg_d = '0;
        cfg_d[CFG_BITS-1 -: 6] = {1'b1, ch_q[0], ch_q[2], ch_q[1], 1'b1, 1'b0};
        ch_next_d = (ch_q == 3'(NUM_CH - 1)) ? 3'd0 : ch_q + 3'd1;
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            ch_q         <= '0;
            prev_ch_q    <= '0;
            first_q      <= 1'b1;
            shift_q      <= '0;
            cfg_sr_q     <= '0;
            adc_convst   <= 1'b0;
            adc_sck      <= 1'b0;
            adc_sdi      <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    adc_convst <= 1'b0;
                    adc_sck    <= 1'b0;
                    adc_sdi    <= 1'b0;
                    first_q    <= 1'b1;
                    if (enable) begin
                        state_q    <= CONV;
                        adc_convst <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                CONV: begin
                    if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                        state_q    <= SHIFT;
                        adc_convst <= 1'b0;
                        adc_sck    <= 1'b0;
                        adc_sdi    <= cfg_d[CFG_BITS-1];
                        cfg_sr_q   <= {cfg_d[CFG_BITS-2:0], 1'b0};
                        cnt_q      <= '0;
                        phase_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!phase_q) begin
                        // SCK rises on this edge; capture SDO at the same edge.
                        adc_sck <= 1'b1;
                        shift_q <= {shift_q[DATA_BITS-2:0], adc_sdo};
                        phase_q <= 1'b1;
                    end else begin
                        adc_sck <= 1'b0;
                        phase_q <= 1'b0;
                        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_q      <= DONE;
                            adc_sdi      <= 1'b0;
                            sample_valid <= ~first_q;
                            if (!first_q) begin
                                sample_data <= shift_q;
                                sample_ch   <= prev_ch_q;
                            end
                            prev_ch_q <= ch_q;
                            ch_q      <= ch_next_d;
                            first_q   <= 1'b0;
                        end else begin
                            cnt_q    <= cnt_q + 1'b1;
                            adc_sdi  <= cfg_sr_q[CFG_BITS-1];
                            cfg_sr_q <= {cfg_sr_q[CFG_BITS-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (enable) begin
                        state_q    <= CONV;
                        adc_convst <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        state_q <= IDLE;
                        first_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural LTC2308-style converter model.
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        adc_sdo = 1'b0;
    logic        adc_convst, adc_sck, adc_sdi, sample_valid, busy;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;

    int vectors = 0;
    int miscompares = 0;

    adc_scan_sequencer #(
        .DATA_BITS  (12),
        .CFG_BITS   (6),
        .NUM_CH     (8),
        .CONV_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .adc_sdo     (adc_sdo),
        .adc_convst  (adc_convst),
        .adc_sck     (adc_sck),
        .adc_sdi     (adc_sdi),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .sample_ch   (sample_ch),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Converter model: mode 0 returns 12'hA5C, mode 1 returns the channel
    // decoded from the config word captured in the previous frame.
    bit          model_mode = 1'b0;
    logic [11:0] cap12 = '0;
    logic [11:0] out_word = '0;
    logic [5:0]  cfg6;
    int          bitp = 0;
    int          sck_cnt = 0;
    int          conv_len = 0;
    int          sck_in_conv = 0;

    always @(posedge adc_convst) begin
        cfg6     = cap12[11:6];
        out_word = model_mode ? {9'd0, cfg6[3], cfg6[2], cfg6[4]} : 12'hA5C;
        bitp     = 0;
        adc_sdo  = out_word[11];
        cap12    = '0;
        sck_cnt  = 0;
        conv_len = 0;
    end

    always @(posedge adc_sck) begin
        if (adc_convst) sck_in_conv++;
        sck_cnt++;
        cap12 = {cap12[10:0], adc_sdi};
        bitp++;
        adc_sdo = (bitp < 12) ? out_word[11 - bitp] : 1'b0;
    end

    always @(posedge clk) if (adc_convst) conv_len++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_valid && n < limit);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int exp_ch;

        // Reset state
        do_reset();
        chk("rst_convst", 32'(adc_convst), 0);
        chk("rst_sck", 32'(adc_sck), 0);
        chk("rst_sdi", 32'(adc_sdi), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_data", 32'(sample_data), 0);
        chk("rst_ch", 32'(sample_ch), 0);
        chk("rst_busy", 32'(busy), 0);

        // Fixed data pattern: start latency, first strobe at cycle 58, then every 29
        model_mode = 1'b0;
        enable = 1'b1;
        tick();
        chk("start_convst", 32'(adc_convst), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_sck", 32'(adc_sck), 0);
        wait_strobe(200, n);
        chk("first_strobe_cycle", 32'(n + 1), 58);
        chk("first_data", 32'(sample_data), 32'h0A5C);
        chk("first_ch", 32'(sample_ch), 0);
        wait_strobe(200, n);
        chk("second_strobe_gap", 32'(n), 29);
        chk("second_data", 32'(sample_data), 32'h0A5C);
        chk("second_ch", 32'(sample_ch), 1);
        tick();
        chk("strobe_one_cycle", 32'(sample_valid), 0);
        chk("data_held", 32'(sample_data), 32'h0A5C);
        chk("ch_held", 32'(sample_ch), 1);

        // Channel wrap with data = channel, SCK/CONVST shape per frame, SDI for ch 5
        do_reset();
        model_mode = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_ch = i % 8;
            wait_strobe(200, n);
            chk($sformatf("wrap_gap_%0d", i), 32'(n), (i == 0) ? 58 : 29);
            chk($sformatf("wrap_ch_%0d", i), 32'(sample_ch), 32'(exp_ch));
            chk($sformatf("wrap_data_%0d", i), 32'(sample_data), 32'(exp_ch));
            chk($sformatf("wrap_sck_cnt_%0d", i), 32'(sck_cnt), 12);
            chk($sformatf("wrap_conv_len_%0d", i), 32'(conv_len), 4);
            if (exp_ch == 4) chk("sdi_ch5", 32'(cap12), 32'b1110_1000_0000);
        end

        // Enable dropped mid-SHIFT: frame completes with strobe, then IDLE
        do_reset();
        enable = 1'b1;
        wait_strobe(200, n);
        chk("drop_f1_ch", 32'(sample_ch), 0);
        wait_strobe(200, n);
        chk("drop_f2_ch", 32'(sample_ch), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("drop_in_shift_busy", 32'(busy), 1);
        chk("drop_in_shift_convst", 32'(adc_convst), 0);
        enable = 1'b0;
        wait_strobe(100, n);
        chk("drop_strobe_gap", 32'(n), 19);
        chk("drop_strobe_ch", 32'(sample_ch), 2);
        chk("drop_strobe_data", 32'(sample_data), 2);
        tick();
        chk("drop_idle_busy", 32'(busy), 0);
        chk("drop_idle_convst", 32'(adc_convst), 0);
        chk("drop_idle_sck", 32'(adc_sck), 0);
        chk("drop_idle_sdi", 32'(adc_sdi), 0);
        chk("drop_idle_valid", 32'(sample_valid), 0);
        chk("drop_idle_data_held", 32'(sample_data), 2);
        for (int i = 0; i < 5; i++) tick();
        chk("drop_still_idle", 32'(busy), 0);
        enable = 1'b1;
        wait_strobe(200, n);
        chk("reen_strobe_cycle", 32'(n), 58);
        chk("reen_strobe_ch", 32'(sample_ch), 4);
        chk("reen_strobe_data", 32'(sample_data), 4);

        // Reset mid-SHIFT
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_sck_active", 32'(busy), 1);
        reset_n = 1'b0;
        enable = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_convst", 32'(adc_convst), 0);
        chk("mid_rst_sck", 32'(adc_sck), 0);
        chk("mid_rst_sdi", 32'(adc_sdi), 0);
        chk("mid_rst_valid", 32'(sample_valid), 0);
        chk("mid_rst_data", 32'(sample_data), 0);
        chk("mid_rst_ch", 32'(sample_ch), 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy), 0);
        enable = 1'b1;
        wait_strobe(200, n);
        chk("post_rst_strobe_cycle", 32'(n), 58);
        chk("post_rst_ch", 32'(sample_ch), 0);
        chk("post_rst_data", 32'(sample_data), 0);
        chk("sck_during_convst", 32'(sck_in_conv), 0);

        enable = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
